// File: rtl/voting_pkg.sv
// Shared definitions for the four-person voting machine: voter count,
// collector state encoding and the result classes used by the tally logic.
package voting_pkg;

  localparam int unsigned N_VOTERS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    EMIT = 2'd2
  } coll_state_t;

  localparam logic [2:0] RES_FAIL = 3'b100;
  localparam logic [2:0] RES_TIE  = 3'b010;
  localparam logic [2:0] RES_PASS = 3'b001;

endpackage

// File: rtl/voter_slot.sv
// Per-voter once-only latch: accepts the first unambiguous press while enabled
// and locks the vote until the next clear.
module voter_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic yes,
  input  logic no,
  output logic voted,
  output logic ballot,
  output logic voted_next
);

  logic accept;

  // A press with both buttons high is ambiguous and leaves the voter free to retry.
  assign accept     = en & ~voted & (yes ^ no);
  assign voted_next = voted | accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted  <= 1'b0;
      ballot <= 1'b0;
    end else if (clr) begin
      voted  <= 1'b0;
      ballot <= 1'b0;
    end else if (accept) begin
      voted  <= 1'b1;
      ballot <= yes;
    end
  end

endmodule

// File: rtl/ballot_collector.sv
// Voting-session front end: opens a timed window, collects one vote per voter
// and emits the ballot vector with a one-cycle valid strobe.
module ballot_collector
  import voting_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int TW            = $clog2(WINDOW_CYCLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_VOTERS-1:0] yes_btn,
  input  logic [N_VOTERS-1:0] no_btn,
  output logic [N_VOTERS-1:0] ballot,
  output logic                ballot_valid,
  output logic [N_VOTERS-1:0] voted,
  output logic                busy,
  output logic                timed_out
);

  localparam logic [TW-1:0] LAST = TW'(WINDOW_CYCLES - 1);

  coll_state_t         state, state_nxt;
  logic [TW-1:0]       timer;
  logic                clr, en, timer_clr, timer_inc, timed_out_nxt;
  logic [N_VOTERS-1:0] voted_next;

  for (genvar i = 0; i < N_VOTERS; i++) begin : g_slot
    voter_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .en         (en),
      .yes        (yes_btn[i]),
      .no         (no_btn[i]),
      .voted      (voted[i]),
      .ballot     (ballot[i]),
      .voted_next (voted_next[i])
    );
  end

  // Close priority: abort, then a full ballot (even on the last window cycle), then expiry.
  always_comb begin
    state_nxt     = state;
    clr           = 1'b0;
    en            = 1'b0;
    timer_clr     = 1'b0;
    timer_inc     = 1'b0;
    timed_out_nxt = timed_out;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = OPEN;
          clr           = 1'b1;
          timer_clr     = 1'b1;
          timed_out_nxt = 1'b0;
        end
      end
      OPEN: begin
        if (abort) begin
          state_nxt = IDLE;
          clr       = 1'b1;
          timer_clr = 1'b1;
        end else begin
          en = 1'b1;
          if (&voted_next) begin
            state_nxt     = EMIT;
            timed_out_nxt = 1'b0;
          end else if (timer == LAST) begin
            state_nxt     = EMIT;
            timed_out_nxt = 1'b1;
          end else begin
            timer_inc = 1'b1;
          end
        end
      end
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      timed_out <= timed_out_nxt;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
    end
  end

  assign busy         = (state != IDLE);
  assign ballot_valid = (state == EMIT);

endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector with a session-level reference model
// checked every cycle plus hand-computed literal expectations.
module tb_ballot_collector;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] yes_btn = '0;
  logic [3:0] no_btn = '0;
  logic [3:0] ballot, voted;
  logic       ballot_valid, busy, timed_out;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  ballot_collector #(.WINDOW_CYCLES(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .yes_btn      (yes_btn),
    .no_btn       (no_btn),
    .ballot       (ballot),
    .ballot_valid (ballot_valid),
    .voted        (voted),
    .busy         (busy),
    .timed_out    (timed_out)
  );

  always #5 clk = ~clk;

  // Session-level model: a session is open, or a result is being announced, or neither.
  bit       m_open = 1'b0;
  bit       m_emit = 1'b0;
  int       m_elapsed = 0;
  bit       m_to = 1'b0;
  bit [3:0] m_voted = '0;
  bit [3:0] m_ballot = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open = 0; m_emit = 0; m_elapsed = 0; m_to = 0;
      m_voted = '0; m_ballot = '0;
    end else if (m_emit) begin
      m_emit = 0;
    end else if (!m_open) begin
      if (start) begin
        m_open = 1; m_elapsed = 0; m_to = 0;
        m_voted = '0; m_ballot = '0;
      end
    end else if (abort) begin
      m_open = 0; m_voted = '0; m_ballot = '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (!m_voted[i] && (yes_btn[i] != no_btn[i])) begin
          m_voted[i]  = 1'b1;
          m_ballot[i] = yes_btn[i];
        end
      if (m_voted == 4'hF) begin
        m_open = 0; m_emit = 1; m_to = 0;
      end else if (m_elapsed == W - 1) begin
        m_open = 0; m_emit = 1; m_to = 1;
      end else begin
        m_elapsed++;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      total++;
      if ({ballot, voted, ballot_valid, busy, timed_out} !==
          {m_ballot, m_voted, m_emit, (m_open | m_emit), m_to}) begin
        bad++;
        $display("FAIL model t=%0t: got ballot=%b voted=%b valid=%b busy=%b to=%b, want ballot=%b voted=%b valid=%b busy=%b to=%b",
                 $time, ballot, voted, ballot_valid, busy, timed_out,
                 m_ballot, m_voted, m_emit, (m_open | m_emit), m_to);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // One cycle of stimulus: inputs held across exactly one rising edge.
  task automatic step(input logic s, input logic a, input logic [3:0] y, input logic [3:0] n);
    start = s; abort = a; yes_btn = y; no_btn = n;
    @(posedge clk); #1;
    start = 0; abort = 0; yes_btn = '0; no_btn = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    checking = 1'b1;

    // Reset in OPEN after two votes
    step(1, 0, '0, '0);
    step(0, 0, 4'b0001, '0);
    step(0, 0, '0, 4'b0010);
    chk("t1_voted_pre", voted, 4'b0011);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_rst_outs", {ballot_valid, busy, timed_out, 1'b0}, 4'b0000);
    chk("t1_rst_voted", voted, 4'b0000);
    chk("t1_rst_ballot", ballot, 4'b0000);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 0, '0, '0);
    chk("t1_reopen", {busy, voted[2:0]}, 4'b1000);
    step(0, 0, '0, '0);
    step(0, 0, 4'b0001, '0);
    step(0, 0, '0, 4'b0010);
    step(0, 0, 4'b0100, '0);
    step(0, 0, '0, 4'b1000);
    chk("t2_ballot", ballot, 4'b0101);
    chk("t2_flags", {ballot_valid, busy, timed_out, 1'b0}, 4'b1100);
    step(0, 0, '0, '0);
    chk("t2_after", {ballot_valid, busy, timed_out, 1'b0}, 4'b0000);

    // Repeats, conflict and window expiry
    step(1, 0, '0, '0);
    step(0, 0, 4'b0010, '0);
    step(0, 0, '0, 4'b0010);
    step(0, 0, 4'b1000, 4'b1000);
    chk("t3_conflict", voted, 4'b0010);
    step(0, 0, 4'b0001, '0);
    step(0, 0, '0, 4'b0100);
    idle(2);
    chk("t3_pre_expiry", {ballot_valid, busy, timed_out, 1'b0}, 4'b0100);
    idle(1);
    chk("t3_expiry", {ballot_valid, busy, timed_out, 1'b0}, 4'b1110);
    chk("t3_ballot", ballot, 4'b0011);
    chk("t3_voted", voted, 4'b0111);
    idle(1);
    chk("t3_hold", {ballot_valid, busy, timed_out, 1'b0}, 4'b0010);

    // Last vote on final window cycle, with a start inside OPEN
    step(1, 0, '0, '0);
    step(0, 0, 4'b0001, '0);
    step(0, 0, 4'b0010, '0);
    step(0, 0, '0, 4'b0100);
    step(1, 0, '0, '0);
    idle(3);
    step(0, 0, 4'b1000, '0);
    chk("t4_flags", {ballot_valid, busy, timed_out, 1'b0}, 4'b1100);
    chk("t4_voted", voted, 4'b1111);
    chk("t4_ballot", ballot, 4'b1011);
    step(1, 0, '0, '0);
    chk("t6_emit_start", {ballot_valid, busy, ballot[1:0]}, 4'b0011);
    step(1, 0, '0, '0);
    chk("t6_restart", {busy, ballot[2:0]}, 4'b1000);

    // Abort beats the fourth vote
    step(0, 0, 4'b0001, '0);
    step(0, 0, 4'b0010, '0);
    step(0, 0, 4'b0100, '0);
    step(0, 1, 4'b1000, '0);
    chk("t5_abort_voted", voted, 4'b0000);
    chk("t5_abort_flags", {ballot_valid, busy, timed_out, 1'b0}, 4'b0000);
    step(0, 1, 4'b1111, '0);
    chk("t5_idle_btn", voted, 4'b0000);
    idle(2);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
